// File: rtl/ethpipe_tx_pkg.sv
// Shared definitions for the ethpipe GMII transmit engine: state encoding,
// framing constants and the reflected CRC-32 byte step.
package ethpipe_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_PRE  = 3'd1;
  localparam state_t ST_DATA = 3'd2;
  localparam state_t ST_FCS  = 3'd3;
  localparam state_t ST_IFG  = 3'd4;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Ethernet sends each byte LSB first, so the register shifts right and
  // uses the bit-reversed polynomial.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ data[i];
      c  = {1'b0, c[31:1]} ^ (fb ? reflect32(CRC_POLY) : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/ethpipe_tx_crc32.sv
// Byte-wide CRC-32 accumulator (module eth_crc32): combinational next value,
// registered state, synchronous clear and enable.
module eth_crc32
  import ethpipe_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_next;

  assign crc_next = crc32_byte(crc, data);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/ethpipe_tx.sv
// GMII transmit engine: preamble/SFD, frame bytes from the slot RAM, optional
// FCS (define ETHPIPE_TX_CRC_EN), then the inter-frame gap.
module ethpipe_tx
  import ethpipe_tx_pkg::*;
#(
  parameter logic [11:0] DATA_BASE    = 12'd3,
  parameter int          IFG_LEN      = 12,
  parameter int          PREAMBLE_LEN = 7
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst,
  input  logic [31:0] global_counter,
  input  logic        tx_start,
  input  logic [11:0] tx_frame_len,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [31:0] tx_timestamp,
  output logic [11:0] slot_tx_eth_address,
  output logic        slot_tx_eth_rd_en,
  input  logic [15:0] slot_tx_eth_q,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en
);

  localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_LEN);
  localparam logic [7:0] PRE_FETCH = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] IFG_LAST  = 8'(IFG_LEN - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [11:0] len_q;
  logic [11:0] idx;
  logic [11:0] words_left;
  logic [7:0]  word_hi;
  logic [7:0]  data_byte;
  logic        rd_issue;

  // The RAM returns a word two edges after the read is registered, so word k
  // is requested two cycles before byte 2k goes out; the first request lands
  // in the preamble.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    rd_issue  = 1'b0;
    data_byte = slot_tx_eth_q[7:0];
    if (idx[0]) data_byte = word_hi;
    if (state == ST_PRE && cnt == PRE_FETCH) rd_issue = 1'b1;
    if (state == ST_DATA && !idx[0] && words_left != 12'd0) rd_issue = 1'b1;
  end

`ifdef ETHPIPE_TX_CRC_EN
  logic [31:0] crc;
  logic [7:0]  fcs_byte;

  eth_crc32 u_crc (
    .clk   (gmii_tx_clk),
    .rst   (sys_rst),
    .clear (state == ST_IDLE),
    .en    (state == ST_DATA),
    .data  (data_byte),
    .crc   (crc)
  );

  assign fcs_byte = ~crc[{cnt[1:0], 3'b000} +: 8];
`endif

  always_ff @(posedge gmii_tx_clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, matching the hardware.
    if (sys_rst) begin
      // NOTE: this block holds no memories, so every register is reset.
      state               <= ST_IDLE;
      cnt                 <= '0;
      len_q               <= '0;
      idx                 <= '0;
      words_left          <= '0;
      word_hi             <= '0;
      tx_busy             <= 1'b0;
      tx_done             <= 1'b0;
      tx_timestamp        <= '0;
      slot_tx_eth_address <= '0;
      slot_tx_eth_rd_en   <= 1'b0;
      gmii_txd            <= '0;
      gmii_tx_en          <= 1'b0;
    end else begin
      tx_done           <= 1'b0;
      slot_tx_eth_rd_en <= 1'b0;

      if (rd_issue) begin
        slot_tx_eth_rd_en   <= 1'b1;
        slot_tx_eth_address <= (state == ST_PRE) ? DATA_BASE
                                                 : slot_tx_eth_address + 12'd1;
        words_left          <= words_left - 12'd1;
      end

      case (state)
        ST_IDLE: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= '0;
          if (tx_start) begin
            if (tx_frame_len != 12'd0) begin
              len_q      <= tx_frame_len;
              words_left <= {1'b0, tx_frame_len[11:1]} + {11'd0, tx_frame_len[0]};
              idx        <= '0;
              cnt        <= '0;
              tx_busy    <= 1'b1;
              state      <= ST_PRE;
            end else begin
              tx_done <= 1'b1;
            end
          end
        end

        ST_PRE: begin
          gmii_tx_en <= 1'b1;
          if (cnt == PRE_LAST) begin
            gmii_txd     <= SFD_BYTE;
            tx_timestamp <= global_counter;
            state        <= ST_DATA;
          end else begin
            gmii_txd <= PREAMBLE_BYTE;
            cnt      <= cnt + 8'd1;
          end
        end

        ST_DATA: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= data_byte;
          if (!idx[0]) word_hi <= slot_tx_eth_q[15:8];
          idx <= idx + 12'd1;
          if (idx == len_q - 12'd1) begin
            cnt <= '0;
`ifdef ETHPIPE_TX_CRC_EN
            state <= ST_FCS;
`else
            state <= ST_IFG;
`endif
          end
        end

`ifdef ETHPIPE_TX_CRC_EN
        ST_FCS: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= fcs_byte;
          if (cnt == 8'd3) begin
            cnt   <= '0;
            state <= ST_IFG;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
`endif

        ST_IFG: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= '0;
          if (cnt == IFG_LAST) begin
            cnt     <= '0;
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= '0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ethpipe_tx.sv
// Self-checking bench for ethpipe_tx: per-cycle output log compared against a
// frame-level reference trace built from slot RAM contents.
module tb_ethpipe_tx;

  localparam int          IFG  = 12;
  localparam logic [11:0] BASE = 12'd3;
`ifdef ETHPIPE_TX_CRC_EN
  localparam int FCS_N = 4;
`else
  localparam int FCS_N = 0;
`endif

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] global_counter = '0;
  logic        tx_start = 1'b0;
  logic [11:0] tx_frame_len = '0;
  logic        tx_busy, tx_done;
  logic [31:0] tx_timestamp;
  logic [11:0] slot_tx_eth_address;
  logic        slot_tx_eth_rd_en;
  logic [15:0] slot_tx_eth_q;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;

  ethpipe_tx dut (
    .gmii_tx_clk         (clk),
    .sys_rst             (sys_rst),
    .global_counter      (global_counter),
    .tx_start            (tx_start),
    .tx_frame_len        (tx_frame_len),
    .tx_busy             (tx_busy),
    .tx_done             (tx_done),
    .tx_timestamp        (tx_timestamp),
    .slot_tx_eth_address (slot_tx_eth_address),
    .slot_tx_eth_rd_en   (slot_tx_eth_rd_en),
    .slot_tx_eth_q       (slot_tx_eth_q),
    .gmii_txd            (gmii_txd),
    .gmii_tx_en          (gmii_tx_en)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];
  always @(posedge clk) if (slot_tx_eth_rd_en) slot_tx_eth_q <= mem[slot_tx_eth_address];

  always @(negedge clk) global_counter = $urandom();

  typedef struct packed { logic en; logic [7:0] txd; logic done; logic busy; } obs_t;
  typedef struct { obs_t o; logic rd; logic [11:0] addr; logic [31:0] gc; logic [31:0] ts; } ent_t;

  ent_t       log_q[$];
  obs_t       exp_q[$];
  logic [7:0] data_q[$];
  logic       logging = 1'b0;
  int         total = 0;
  int         bad = 0;

  // Entry j of the log holds the outputs just after edge N+j, where edge N
  // sampled the start; gc is the timestamp source as seen by edge N+j.
  always @(posedge clk) begin : logger
    ent_t e;
    e.gc = global_counter;
    #1;
    e.o    = '{en: gmii_tx_en, txd: gmii_txd, done: tx_done, busy: tx_busy};
    e.rd   = slot_tx_eth_rd_en;
    e.addr = slot_tx_eth_address;
    e.ts   = tx_timestamp;
    if (logging) log_q.push_back(e);
  end

`ifdef ETHPIPE_TX_CRC_EN
  function automatic logic [31:0] crc32_ref(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, data_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction
`endif

  // Bytes that must appear on the wire after the SFD.
  task automatic make_frame(input int len);
    logic [15:0] w;
    logic [11:0] a;
    logic [31:0] c;
    data_q.delete();
    for (int i = 0; i < len; i++) begin
      a = BASE + 12'(i / 2);
      w = mem[a];
      data_q.push_back((i % 2 == 1) ? w[15:8] : w[7:0]);
    end
    c = '0;
`ifdef ETHPIPE_TX_CRC_EN
    if (len > 0) begin
      c = crc32_ref(len);
      for (int j = 0; j < 4; j++) data_q.push_back(c[8*j +: 8]);
    end
`endif
    if (c != c) data_q.delete();
  endtask

  task automatic build_expect(input int len);
    exp_q.delete();
    if (len == 0) begin
      exp_q.push_back('{en: 1'b0, txd: 8'h00, done: 1'b1, busy: 1'b0});
    end else begin
      exp_q.push_back('{en: 1'b0, txd: 8'h00, done: 1'b0, busy: 1'b1});
      for (int i = 0; i < 7; i++) exp_q.push_back('{en: 1'b1, txd: 8'h55, done: 1'b0, busy: 1'b1});
      exp_q.push_back('{en: 1'b1, txd: 8'hD5, done: 1'b0, busy: 1'b1});
      foreach (data_q[i]) exp_q.push_back('{en: 1'b1, txd: data_q[i], done: 1'b0, busy: 1'b1});
      for (int i = 0; i < IFG - 1; i++) exp_q.push_back('{en: 1'b0, txd: 8'h00, done: 1'b0, busy: 1'b1});
      exp_q.push_back('{en: 1'b0, txd: 8'h00, done: 1'b1, busy: 1'b0});
    end
    exp_q.push_back('{en: 1'b0, txd: 8'h00, done: 1'b0, busy: 1'b0});
  endtask

  function automatic int first_diff(input int off, input int n);
    for (int i = 0; i < n; i++) begin
      if (off + i >= log_q.size()) return i;
      if (log_q[off+i].o !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic obs_t obs_at(input int i);
    if (i < log_q.size()) return log_q[i].o;
    return 'x;
  endfunction

  function automatic int count_en();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].o.en) n++;
    return n;
  endfunction

  function automatic int count_done();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].o.done) n++;
    return n;
  endfunction

  function automatic int count_rises();
    int n = 0;
    for (int i = 1; i < log_q.size(); i++) if (log_q[i].o.en && !log_q[i-1].o.en) n++;
    return n;
  endfunction

  // Read statistics over log entries [off, end).
  task automatic scan_reads(input int off, output int cnt, output logic [11:0] first,
                            output logic [11:0] last, output bit ok);
    int prev_i;
    cnt = 0; first = '0; last = '0; ok = 1'b1; prev_i = -10;
    for (int i = off; i < log_q.size(); i++) begin
      if (log_q[i].rd) begin
        if (cnt == 0) first = log_q[i].addr;
        else if (log_q[i].addr != last + 12'd1 || i - prev_i < 2) ok = 1'b0;
        last = log_q[i].addr;
        prev_i = i;
        cnt++;
      end
    end
  endtask

  task automatic start_frame(input int len);
    @(negedge clk);
    tx_frame_len = 12'(len);
    tx_start = 1'b1;
    log_q.delete();
    logging = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_frame_len = 12'($urandom_range(1, 4095));
  endtask

  task automatic pulse_at_edge(input int edge_idx, input int len);
    while (log_q.size() < edge_idx) @(negedge clk);
    tx_frame_len = 12'(len);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic run_frame(input string name, input int len);
    int d, rc;
    logic [11:0] rf, rl;
    bit rok;
    make_frame(len);
    build_expect(len);
    start_frame(len);
    repeat (exp_q.size() + 4) @(negedge clk);
    logging = 1'b0;
    d = first_diff(0, exp_q.size());
    total++;
    if (d >= 0) begin
      bad++;
      $display("FAIL %s_trace len=%0d cycle %0d: got %h want %h", name, len, d, obs_at(d), exp_q[d]);
    end
    scan_reads(0, rc, rf, rl, rok);
    total++;
    if (rc != (len + 1) / 2 || rf !== BASE || rl !== BASE + 12'((len + 1) / 2 - 1) || !rok) begin
      bad++;
      $display("FAIL %s_reads len=%0d: got cnt=%0d first=%0d last=%0d ok=%0b want cnt=%0d first=%0d last=%0d ok=1",
               name, len, rc, rf, rl, rok, (len + 1) / 2, BASE, BASE + 12'((len + 1) / 2 - 1));
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom());
    repeat (3) @(negedge clk);
    total++;
    if ({gmii_tx_en, gmii_txd, tx_busy, tx_done, slot_tx_eth_rd_en, slot_tx_eth_address, tx_timestamp} !== '0) begin
      bad++;
      $display("FAIL reset_values: en=%b txd=%h busy=%b done=%b rd=%b addr=%h ts=%h want all 0",
               gmii_tx_en, gmii_txd, tx_busy, tx_done, slot_tx_eth_rd_en, slot_tx_eth_address, tx_timestamp);
    end
    sys_rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if ({gmii_tx_en, gmii_txd, tx_busy, tx_done, slot_tx_eth_rd_en} !== '0) begin
      bad++;
      $display("FAIL idle_after_reset: en=%b txd=%h busy=%b done=%b rd=%b want all 0",
               gmii_tx_en, gmii_txd, tx_busy, tx_done, slot_tx_eth_rd_en);
    end
  endtask

  task automatic test_preamble_timing();
    run_frame("pre60", 60);
    total++;
    if (log_q[9].o.txd !== mem[3][7:0]) begin
      bad++;
      $display("FAIL pre60_byte0: got %h want %h", log_q[9].o.txd, mem[3][7:0]);
    end
    total++;
    if (count_en() != 8 + 60 + FCS_N) begin
      bad++;
      $display("FAIL pre60_en_cycles: got %0d want %0d", count_en(), 8 + 60 + FCS_N);
    end
    total++;
    if (log_q[9].ts !== log_q[8].gc) begin
      bad++;
      $display("FAIL pre60_timestamp: got %h want %h", log_q[9].ts, log_q[8].gc);
    end
  endtask

  task automatic test_odd_length();
    mem[3] = 16'hBBAA;
    mem[4] = 16'hDDCC;
    mem[5] = 16'h11EE;
    run_frame("odd5", 5);
  endtask

`ifdef ETHPIPE_TX_CRC_EN
  task automatic test_crc();
    logic [31:0] got;
    mem[3] = 16'h3231;
    mem[4] = 16'h3433;
    mem[5] = 16'h3635;
    mem[6] = 16'h3837;
    mem[7] = {8'($urandom()), 8'h39};
    run_frame("crc9", 9);
    got = {log_q[21].o.txd, log_q[20].o.txd, log_q[19].o.txd, log_q[18].o.txd};
    total++;
    if (got !== 32'hCBF4_3926) begin
      bad++;
      $display("FAIL crc9_fcs: got bytes(msb..lsb) %h want cbf43926", got);
    end
  endtask
`endif

  task automatic test_random_frames();
    for (int f = 0; f < 5; f++) begin
      for (int w = 0; w < 64; w++) mem[BASE + 12'(w)] = 16'($urandom());
      run_frame("rand", $urandom_range(1, 90));
    end
  endtask

  task automatic test_back_to_back();
    int a, b, k, d, off;
    a = $urandom_range(1, 40);
    b = $urandom_range(1, 40);
    for (int w = 0; w < 64; w++) mem[BASE + 12'(w)] = 16'($urandom());
    start_frame(a);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tx_done !== 1'b1 && k < 500);
    total++;
    if (tx_done !== 1'b1) begin
      bad++;
      logging = 1'b0;
      $display("FAIL b2b_done_timeout: tx_done=%b after %0d cycles want 1", tx_done, k);
      return;
    end
    tx_frame_len = 12'(b);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (8 + b + FCS_N + IFG + 6) @(negedge clk);
    logging = 1'b0;
    make_frame(a);
    build_expect(a);
    off = exp_q.size() - 1;
    d = first_diff(0, exp_q.size() - 1);
    total++;
    if (d >= 0) begin
      bad++;
      $display("FAIL b2b_first_trace len=%0d cycle %0d: got %h want %h", a, d, obs_at(d), exp_q[d]);
    end
    make_frame(b);
    build_expect(b);
    d = first_diff(off, exp_q.size());
    total++;
    if (d >= 0) begin
      bad++;
      $display("FAIL b2b_second_trace len=%0d cycle %0d: got %h want %h", b, d, obs_at(off + d), exp_q[d]);
    end
  endtask

  task automatic test_busy_ignore();
    int d;
    for (int w = 0; w < 64; w++) mem[BASE + 12'(w)] = 16'($urandom());
    make_frame(30);
    build_expect(30);
    start_frame(30);
    pulse_at_edge(20, 7);
    pulse_at_edge(14 + 30 + FCS_N, 9);
    repeat (exp_q.size() + 10) @(negedge clk);
    logging = 1'b0;
    d = first_diff(0, exp_q.size());
    total++;
    if (d >= 0) begin
      bad++;
      $display("FAIL busy_trace cycle %0d: got %h want %h", d, obs_at(d), exp_q[d]);
    end
    total++;
    if (count_rises() != 1) begin
      bad++;
      $display("FAIL busy_frames: got %0d frames want 1", count_rises());
    end
    total++;
    if (count_done() != 1) begin
      bad++;
      $display("FAIL busy_done_pulses: got %0d want 1", count_done());
    end
  endtask

  task automatic test_zero_length();
    int d;
    make_frame(0);
    build_expect(0);
    start_frame(0);
    repeat (20) @(negedge clk);
    logging = 1'b0;
    d = first_diff(0, exp_q.size());
    total++;
    if (d >= 0) begin
      bad++;
      $display("FAIL zero_trace cycle %0d: got %h want %h", d, obs_at(d), exp_q[d]);
    end
    total++;
    if (count_en() != 0) begin
      bad++;
      $display("FAIL zero_tx_en: got %0d enabled cycles want 0", count_en());
    end
    total++;
    if (count_done() != 1) begin
      bad++;
      $display("FAIL zero_done_pulses: got %0d want 1", count_done());
    end
  endtask

  task automatic test_reset_mid_frame();
    int viol;
    for (int w = 0; w < 64; w++) mem[BASE + 12'(w)] = 16'($urandom());
    make_frame(60);
    start_frame(60);
    while (log_q.size() < 30) @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    repeat (40) @(negedge clk);
    logging = 1'b0;
    total++;
    if (log_q[29].o.en !== 1'b1 || log_q[29].o.txd !== data_q[20]) begin
      bad++;
      $display("FAIL rstmid_byte20: got en=%b txd=%h want en=1 txd=%h", log_q[29].o.en, log_q[29].o.txd, data_q[20]);
    end
    viol = 0;
    for (int i = 30; i < log_q.size(); i++) if (log_q[i].o.en || log_q[i].o.txd != 8'h00) viol++;
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL rstmid_tx_en_low: got %0d active cycles after reset want 0", viol);
    end
    total++;
    if (count_done() != 0) begin
      bad++;
      $display("FAIL rstmid_no_done: got %0d done pulses want 0", count_done());
    end
    run_frame("after_rst", 25);
  endtask

  initial begin
    test_reset();
    test_preamble_timing();
    test_odd_length();
`ifdef ETHPIPE_TX_CRC_EN
    test_crc();
`endif
    test_random_frames();
    test_back_to_back();
    test_busy_ignore();
    test_zero_length();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
